// File: rtl/aclk_time_counter.sv
// Time-of-day counter for the alarm clock: four BCD digits (hh:mm) that
// advance once per one_minute strobe, accept a validated load from the
// keypad path, and pulse rollover when the day wraps.
module aclk_time_counter #(
    parameter int         H24      = 1,     // 1: 00:00..23:59, 0: 01:00..12:59
    parameter logic [3:0] RST_MSHR = 4'd0,  // reset tens-of-hours digit
    parameter logic [3:0] RST_LSHR = 4'd0   // reset units-of-hours digit
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_minute,
    input  logic       load_new_c,
    input  logic [3:0] new_current_time_ms_hr,
    input  logic [3:0] new_current_time_ls_hr,
    input  logic [3:0] new_current_time_ms_min,
    input  logic [3:0] new_current_time_ls_min,
    output logic [3:0] current_time_ms_hr,
    output logic [3:0] current_time_ls_hr,
    output logic [3:0] current_time_ms_min,
    output logic [3:0] current_time_ls_min,
    output logic       load_err,
    output logic       rollover
);

    // Registered state
    logic [3:0] ms_hr_q,  ms_hr_d;
    logic [3:0] ls_hr_q,  ls_hr_d;
    logic [3:0] ms_min_q, ms_min_d;
    logic [3:0] ls_min_q, ls_min_d;
    logic       load_err_q, load_err_d;
    logic       rollover_q, rollover_d;

    // Result of advancing the held time by one minute
    logic [3:0] tick_ms_hr;
    logic [3:0] tick_ls_hr;
    logic [3:0] tick_ms_min;
    logic [3:0] tick_ls_min;
    logic       tick_rollover;

    logic       cur_ok;
    logic       new_ok;

    // Hour digits form a legal hour for the configured range.
    function automatic logic hour_ok(input logic [3:0] ms, input logic [3:0] ls);
        logic ok;
        if (H24 != 0) begin
            ok = ((ms < 4'd2) && (ls <= 4'd9)) ||
                 ((ms == 4'd2) && (ls <= 4'd3));
        end else begin
            ok = ((ms == 4'd0) && (ls >= 4'd1) && (ls <= 4'd9)) ||
                 ((ms == 4'd1) && (ls <= 4'd2));
        end
        return ok;
    endfunction

    // All four digits together form a legal time of day.
    function automatic logic time_ok(input logic [3:0] ms_hr,
                                     input logic [3:0] ls_hr,
                                     input logic [3:0] ms_min,
                                     input logic [3:0] ls_min);
        return hour_ok(ms_hr, ls_hr) && (ms_min <= 4'd5) && (ls_min <= 4'd9);
    endfunction

    assign cur_ok = time_ok(ms_hr_q, ls_hr_q, ms_min_q, ls_min_q);
    assign new_ok = time_ok(new_current_time_ms_hr, new_current_time_ls_hr,
                            new_current_time_ms_min, new_current_time_ls_min);

    // One-minute advance with BCD carry chain and day wrap; illegal held time recovers to reset value.
    always_comb begin
        tick_ms_hr    = ms_hr_q;
        tick_ls_hr    = ls_hr_q;
        tick_ms_min   = ms_min_q;
        tick_ls_min   = ls_min_q;
        tick_rollover = 1'b0;

        if (!cur_ok) begin
            tick_ms_hr  = RST_MSHR;
            tick_ls_hr  = RST_LSHR;
            tick_ms_min = 4'd0;
            tick_ls_min = 4'd0;
        end else if (ls_min_q != 4'd9) begin
            tick_ls_min = ls_min_q + 4'd1;
        end else begin
            tick_ls_min = 4'd0;
            if (ms_min_q != 4'd5) begin
                tick_ms_min = ms_min_q + 4'd1;
            end else begin
                // Minutes wrap: carry into the hour
                tick_ms_min = 4'd0;
                if ((H24 != 0) && (ms_hr_q == 4'd2) && (ls_hr_q == 4'd3)) begin
                    tick_ms_hr    = 4'd0;
                    tick_ls_hr    = 4'd0;
                    tick_rollover = 1'b1;
                end else if ((H24 == 0) && (ms_hr_q == 4'd1) && (ls_hr_q == 4'd2)) begin
                    // 12:59 -> 01:00 is not the day wrap in 12-hour mode
                    tick_ms_hr = 4'd0;
                    tick_ls_hr = 4'd1;
                end else if ((H24 == 0) && (ms_hr_q == 4'd1) && (ls_hr_q == 4'd1)) begin
                    tick_ms_hr    = 4'd1;
                    tick_ls_hr    = 4'd2;
                    tick_rollover = 1'b1;
                end else if (ls_hr_q == 4'd9) begin
                    tick_ls_hr = 4'd0;
                    tick_ms_hr = ms_hr_q + 4'd1;
                end else begin
                    tick_ls_hr = ls_hr_q + 4'd1;
                end
            end
        end
    end

    // Next-state select: load beats tick beats hold; pulses default low.
    always_comb begin
        ms_hr_d    = ms_hr_q;
        ls_hr_d    = ls_hr_q;
        ms_min_d   = ms_min_q;
        ls_min_d   = ls_min_q;
        load_err_d = 1'b0;
        rollover_d = 1'b0;

        if (load_new_c) begin
            // A coincident tick is deliberately dropped
            if (new_ok) begin
                ms_hr_d  = new_current_time_ms_hr;
                ls_hr_d  = new_current_time_ls_hr;
                ms_min_d = new_current_time_ms_min;
                ls_min_d = new_current_time_ls_min;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (one_minute) begin
            ms_hr_d    = tick_ms_hr;
            ls_hr_d    = tick_ls_hr;
            ms_min_d   = tick_ms_min;
            ls_min_d   = tick_ls_min;
            rollover_d = tick_rollover;
        end
    end

    // State register with asynchronous return to the reset time.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ms_hr_q    <= RST_MSHR;
            ls_hr_q    <= RST_LSHR;
            ms_min_q   <= 4'd0;
            ls_min_q   <= 4'd0;
            load_err_q <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            ms_hr_q    <= ms_hr_d;
            ls_hr_q    <= ls_hr_d;
            ms_min_q   <= ms_min_d;
            ls_min_q   <= ls_min_d;
            load_err_q <= load_err_d;
            rollover_q <= rollover_d;
        end
    end

    assign current_time_ms_hr  = ms_hr_q;
    assign current_time_ls_hr  = ls_hr_q;
    assign current_time_ms_min = ms_min_q;
    assign current_time_ls_min = ls_min_q;
    assign load_err            = load_err_q;
    assign rollover            = rollover_q;

endmodule

// File: tb/tb_aclk_time_counter.sv
// Directed bench for aclk_time_counter: a 24-hour instance and a 12-hour
// instance share clock and reset; each step drives one cycle of strobes and
// compares the registered outputs against hand-computed BCD times.
`timescale 1ns/1ps
module tb_aclk_time_counter;

    logic clock = 1'b0;
    logic reset = 1'b1;

    // 24-hour instance
    logic        a_tick = 1'b0, a_load = 1'b0;
    logic [15:0] a_new  = 16'h0000;
    logic [3:0]  a_mh, a_lh, a_mm, a_lm;
    logic        a_err, a_roll;
    logic [15:0] a_time;

    // 12-hour instance
    logic        b_tick = 1'b0, b_load = 1'b0;
    logic [15:0] b_new  = 16'h0000;
    logic [3:0]  b_mh, b_lh, b_mm, b_lm;
    logic        b_err, b_roll;
    logic [15:0] b_time;

    int checks_total = 0;
    int checks_failed = 0;

    always #5 clock = ~clock;

    assign a_time = {a_mh, a_lh, a_mm, a_lm};
    assign b_time = {b_mh, b_lh, b_mm, b_lm};

    aclk_time_counter #(.H24(1), .RST_MSHR(4'd0), .RST_LSHR(4'd0)) dut24 (
        .clock(clock), .reset(reset),
        .one_minute(a_tick), .load_new_c(a_load),
        .new_current_time_ms_hr(a_new[15:12]), .new_current_time_ls_hr(a_new[11:8]),
        .new_current_time_ms_min(a_new[7:4]),  .new_current_time_ls_min(a_new[3:0]),
        .current_time_ms_hr(a_mh), .current_time_ls_hr(a_lh),
        .current_time_ms_min(a_mm), .current_time_ls_min(a_lm),
        .load_err(a_err), .rollover(a_roll)
    );

    aclk_time_counter #(.H24(0), .RST_MSHR(4'd1), .RST_LSHR(4'd2)) dut12 (
        .clock(clock), .reset(reset),
        .one_minute(b_tick), .load_new_c(b_load),
        .new_current_time_ms_hr(b_new[15:12]), .new_current_time_ls_hr(b_new[11:8]),
        .new_current_time_ms_min(b_new[7:4]),  .new_current_time_ls_min(b_new[3:0]),
        .current_time_ms_hr(b_mh), .current_time_ls_hr(b_lh),
        .current_time_ms_min(b_mm), .current_time_ls_min(b_lm),
        .load_err(b_err), .rollover(b_roll)
    );

    task automatic check_val(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
        checks_total++;
        if (observed !== expected) begin
            checks_failed++;
            $display("FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of strobes into the selected instance, then settle 1ns after the edge.
    task automatic step(input bit sel12, input bit ld, input bit tk, input logic [15:0] t);
        @(negedge clock);
        if (sel12) begin
            b_load = ld; b_tick = tk; b_new = t;
        end else begin
            a_load = ld; a_tick = tk; a_new = t;
        end
        @(posedge clock);
        #1;
        a_load = 1'b0; a_tick = 1'b0;
        b_load = 1'b0; b_tick = 1'b0;
        $display("step dut%s ld=%0b tk=%0b new=%h -> t24=%h err=%0b roll=%0b | t12=%h err=%0b roll=%0b",
                 sel12 ? "12" : "24", ld, tk, t, a_time, a_err, a_roll, b_time, b_err, b_roll);
    endtask

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_val("rst_t24", a_time, 16'h0000);
        check_val("rst_err24", {15'd0, a_err}, 16'd0);
        check_val("rst_roll24", {15'd0, a_roll}, 16'd0);
        check_val("rst_t12", b_time, 16'h1200);
        @(negedge clock);
        reset = 1'b0;

        // Wide strobe: three high cycles count three minutes
        @(negedge clock);
        a_tick = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_val("wide_tick", a_time, 16'h0003);
        // Reset while still ticking takes effect before the next edge
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_val("async_rst", a_time, 16'h0000);
        @(negedge clock);
        a_tick = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        // Load then carry into ls_hr
        step(0, 1, 0, 16'h1258); check_val("load_1258", a_time, 16'h1258);
        check_val("load_ok_err", {15'd0, a_err}, 16'd0);
        step(0, 0, 1, 16'h0000); check_val("tick_1259", a_time, 16'h1259);
        step(0, 0, 1, 16'h0000); check_val("tick_1300", a_time, 16'h1300);
        step(0, 1, 0, 16'h0959);
        step(0, 0, 1, 16'h0000); check_val("tick_1000", a_time, 16'h1000);

        // Day wrap
        step(0, 1, 0, 16'h2359);
        step(0, 0, 1, 16'h0000); check_val("wrap_t", a_time, 16'h0000);
        check_val("wrap_roll", {15'd0, a_roll}, 16'd1);
        step(0, 0, 0, 16'h0000); check_val("wrap_roll_off", {15'd0, a_roll}, 16'd0);
        check_val("idle_hold", a_time, 16'h0000);

        // Rejected loads
        step(0, 1, 0, 16'h1045); check_val("pre_bad", a_time, 16'h1045);
        step(0, 1, 0, 16'h2400); check_val("bad24_t", a_time, 16'h1045);
        check_val("bad24_err", {15'd0, a_err}, 16'd1);
        step(0, 0, 0, 16'h0000); check_val("err_off", {15'd0, a_err}, 16'd0);
        step(0, 1, 0, 16'h1960); check_val("bad60_t", a_time, 16'h1045);
        check_val("bad60_err", {15'd0, a_err}, 16'd1);
        step(0, 1, 0, 16'h120A); check_val("badA_t", a_time, 16'h1045);
        check_val("badA_err", {15'd0, a_err}, 16'd1);

        // Load wins over coincident tick
        step(0, 1, 1, 16'h0730); check_val("ld_tick", a_time, 16'h0730);
        check_val("ld_tick_err", {15'd0, a_err}, 16'd0);

        // 12-hour instance
        step(1, 1, 0, 16'h1259);
        step(1, 0, 1, 16'h0000); check_val("h12_0100", b_time, 16'h0100);
        check_val("h12_noroll", {15'd0, b_roll}, 16'd0);
        step(1, 1, 0, 16'h1159);
        step(1, 0, 1, 16'h0000); check_val("h12_1200", b_time, 16'h1200);
        check_val("h12_roll", {15'd0, b_roll}, 16'd1);
        step(1, 1, 0, 16'h0030); check_val("h12_bad_t", b_time, 16'h1200);
        check_val("h12_bad_err", {15'd0, b_err}, 16'd1);
        check_val("h12_roll_off", {15'd0, b_roll}, 16'd0);
        check_val("a_untouched", a_time, 16'h0730);

        $display("End of test - %0d assertions evaluated, %0d failures", checks_total, checks_failed);
        $finish;
    end

endmodule
